// File: rtl/fifo_burst_reader.sv
// Read-side burst engine: issues FIFO reads for a fixed-length burst and
// replays the returned words on a valid/ready stream through a 2-entry buffer.
module fifo_burst_reader #(
    parameter int addresswidth = 5,
    parameter int datawidth    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [addresswidth:0] burst_len,
    input  logic                  emp,
    input  logic                  wr,
    input  logic                  rd_en,
    input  logic [datawidth-1:0]  rd_data,
    output logic                  rd,
    output logic                  out_valid,
    output logic [datawidth-1:0]  out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    // Handshake: a word transfers on any rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and a shown word stays until taken.

    localparam int CW = addresswidth + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        len;
    logic [CW-1:0]        issued;
    logic [CW-1:0]        delivered;
    logic [1:0]           occ;
    logic                 head;
    logic [datawidth-1:0] mem [2];

    logic pop;
    logic capture;
    logic tail;

    assign pop       = out_valid && out_ready;
    assign capture   = rd_en && (state != IDLE);
    assign tail      = head ^ occ[0];
    assign out_valid = (occ != 2'd0);
    assign out_data  = mem[head];
    assign out_last  = out_valid && (delivered == len - CW'(1));
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // A read is only issued if its returning word is guaranteed a buffer slot,
    // counting the word already in flight and any pop happening this cycle.
    always_comb begin
        rd = 1'b0;
        if (state == RUN && issued < len && !emp && !wr)
            rd = ({1'b0, occ} + {2'b00, capture}) < (3'd2 + {2'b00, pop});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            issued    <= '0;
            delivered <= '0;
            occ       <= 2'd0;
            head      <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (capture)
                mem[tail] <= rd_data;
            if (pop) begin
                head      <= ~head;
                delivered <= delivered + CW'(1);
            end
            occ <= occ + {1'b0, capture} - {1'b0, pop};
            if (rd)
                issued <= issued + CW'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            len       <= burst_len;
                            issued    <= '0;
                            delivered <= '0;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (rd && (issued + CW'(1) == len))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
